// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with tkeep/tuser sideband, occupancy reporting
// and an optional store-and-forward mode that discards bad or oversize frames.
module axis_pkt_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_DEPTH  = 4,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned PACKET_MODE = 0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [ADDR_DEPTH:0]     fill_count,
  output logic [ADDR_DEPTH:0]     pkt_count,
  output logic                    drop
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH  = ADDR_DEPTH + 1;
  localparam int unsigned DEPTH      = 2 ** ADDR_DEPTH;
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [WORD_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PTR_WIDTH-1:0]   wr_commit, wr_commit_nxt;
  logic [PTR_WIDTH-1:0]   rd_ptr, rd_ptr_nxt;
  logic [PTR_WIDTH-1:0]   pkt_count_nxt;
  logic                   drop_nxt;
  logic                   full;
  logic                   wr_en;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   rd_last;
  logic                   commit;

  assign fill_count = wr_ptr - rd_ptr;
  assign full       = (fill_count == PTR_WIDTH'(DEPTH));

  // Asynchronous read port at the head of the queue
  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = mem[rd_ptr[ADDR_DEPTH-1:0]];

  // Packet mode only exposes words once a whole good packet has been committed
  assign m_tvalid = !areset &&
                    ((PACKET_MODE != 0) ? (pkt_count != '0) : (wr_commit != rd_ptr));

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    rd_ptr_nxt    = rd_ptr;
    pkt_count_nxt = pkt_count;
    drop_nxt      = 1'b0;
    wr_en         = 1'b0;
    commit        = 1'b0;
    s_tready      = 1'b0;

    if (!areset) begin
      if ((PACKET_MODE != 0) && (state == DROP)) s_tready = 1'b1;
      else                                        s_tready = !full;
    end

    wr_acc  = s_tvalid & s_tready;
    rd_acc  = m_tvalid & m_tready;
    rd_last = rd_acc & m_tlast;

    if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_WIDTH'(1);

    if (PACKET_MODE == 0) begin
      if (wr_acc) begin
        wr_en         = 1'b1;
        wr_ptr_nxt    = wr_ptr + PTR_WIDTH'(1);
        wr_commit_nxt = wr_ptr + PTR_WIDTH'(1);
        commit        = s_tlast;
      end
    end else begin
      case (state)
        ACCEPT: begin
          if (wr_acc) begin
            if (!s_tlast) begin
              wr_en      = 1'b1;
              wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
            end else if (!s_tuser[0]) begin
              wr_en         = 1'b1;
              wr_ptr_nxt    = wr_ptr + PTR_WIDTH'(1);
              wr_commit_nxt = wr_ptr + PTR_WIDTH'(1);
              commit        = 1'b1;
            end else begin
              wr_ptr_nxt = wr_commit;
              drop_nxt   = 1'b1;
            end
          end else if (full && (wr_commit == rd_ptr)) begin
            // Storage holds one unterminated packet: it can never complete
            wr_ptr_nxt = wr_commit;
            state_nxt  = DROP;
            drop_nxt   = 1'b1;
          end
        end
        DROP: begin
          if (wr_acc && s_tlast) state_nxt = ACCEPT;
        end
        default: state_nxt = ACCEPT;
      endcase
    end

    if (commit && !rd_last)      pkt_count_nxt = pkt_count + PTR_WIDTH'(1);
    else if (!commit && rd_last) pkt_count_nxt = pkt_count - PTR_WIDTH'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
      rd_ptr    <= rd_ptr_nxt;
      pkt_count <= pkt_count_nxt;
      drop      <= drop_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[ADDR_DEPTH-1:0]] <= {s_tdata, s_tkeep, s_tuser, s_tlast};
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: three configurations share one stimulus stream and
// are each compared every cycle against a queue-based packet model.
module tb_axis_pkt_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned WW = DW + KW + 2;
  localparam int          NDUT = 3;
  typedef logic [WW-1:0] word_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tuser;
  logic          s_tlast;
  logic          s_tvalid;
  logic          m_tready;

  logic          rdy0, vld0, last0, usr0, drop0;
  logic [DW-1:0] data0;
  logic [KW-1:0] keep0;
  logic [4:0]    fill0, pkt0;
  logic          rdy1, vld1, last1, usr1, drop1;
  logic [DW-1:0] data1;
  logic [KW-1:0] keep1;
  logic [4:0]    fill1, pkt1;
  logic          rdy2, vld2, last2, usr2, drop2;
  logic [DW-1:0] data2;
  logic [KW-1:0] keep2;
  logic [2:0]    fill2, pkt2;

  always #5 aclk = ~aclk;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(4), .USER_WIDTH(1), .PACKET_MODE(0)) u_ct (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(rdy0), .m_tdata(data0), .m_tkeep(keep0),
    .m_tuser(usr0), .m_tlast(last0), .m_tvalid(vld0), .m_tready(m_tready),
    .fill_count(fill0), .pkt_count(pkt0), .drop(drop0));

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(4), .USER_WIDTH(1), .PACKET_MODE(1)) u_pk (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(rdy1), .m_tdata(data1), .m_tkeep(keep1),
    .m_tuser(usr1), .m_tlast(last1), .m_tvalid(vld1), .m_tready(m_tready),
    .fill_count(fill1), .pkt_count(pkt1), .drop(drop1));

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(2), .USER_WIDTH(1), .PACKET_MODE(1)) u_pk_small (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(rdy2), .m_tdata(data2), .m_tkeep(keep2),
    .m_tuser(usr2), .m_tlast(last2), .m_tvalid(vld2), .m_tready(m_tready),
    .fill_count(fill2), .pkt_count(pkt2), .drop(drop2));

  logic        obs_ready [NDUT];
  logic        obs_valid [NDUT];
  logic        obs_drop  [NDUT];
  word_t       obs_word  [NDUT];
  int unsigned obs_fill  [NDUT];
  int unsigned obs_pkt   [NDUT];

  assign obs_ready[0] = rdy0;  assign obs_ready[1] = rdy1;  assign obs_ready[2] = rdy2;
  assign obs_valid[0] = vld0;  assign obs_valid[1] = vld1;  assign obs_valid[2] = vld2;
  assign obs_drop[0]  = drop0; assign obs_drop[1]  = drop1; assign obs_drop[2]  = drop2;
  assign obs_word[0]  = {data0, keep0, usr0, last0};
  assign obs_word[1]  = {data1, keep1, usr1, last1};
  assign obs_word[2]  = {data2, keep2, usr2, last2};
  assign obs_fill[0]  = 32'(fill0); assign obs_fill[1] = 32'(fill1); assign obs_fill[2] = 32'(fill2);
  assign obs_pkt[0]   = 32'(pkt0);  assign obs_pkt[1]  = 32'(pkt1);  assign obs_pkt[2]  = 32'(pkt2);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed beats readable in order, plus the open packet
  word_t cq [NDUT][$];
  word_t pq [NDUT][$];
  bit    dropping [NDUT];
  bit    drop_exp [NDUT];

  // Observed activity for the directed checks
  bit    acc_flag [NDUT];
  int    rd_n     [NDUT];
  int    drop_n   [NDUT];
  word_t outq     [NDUT][$];

  function automatic int depth_of(input int k);
    return (k == 2) ? 4 : 16;
  endfunction

  function automatic bit pmode(input int k);
    return k != 0;
  endfunction

  function automatic int pkts(input int k);
    int n = 0;
    for (int i = 0; i < cq[k].size(); i++) if (cq[k][i][0]) n++;
    return n;
  endfunction

  function automatic int words(input int k);
    return cq[k].size() + pq[k].size();
  endfunction

  function automatic bit exp_ready(input int k);
    return !areset && (dropping[k] || words(k) < depth_of(k));
  endfunction

  function automatic bit exp_valid(input int k);
    if (areset) return 1'b0;
    return pmode(k) ? (pkts(k) > 0) : (cq[k].size() > 0);
  endfunction

  task automatic update_model(input int k, input bit acc, input bit rd, input word_t w);
    bit stuck;
    if (areset) begin
      cq[k].delete(); pq[k].delete();
      dropping[k] = 1'b0; drop_exp[k] = 1'b0;
      return;
    end
    stuck = (words(k) == depth_of(k)) && (cq[k].size() == 0);
    drop_exp[k] = 1'b0;
    if (rd) void'(cq[k].pop_front());
    if (!pmode(k)) begin
      if (acc) cq[k].push_back(w);
    end else if (dropping[k]) begin
      if (acc && w[0]) dropping[k] = 1'b0;
    end else if (acc) begin
      if (!w[0]) pq[k].push_back(w);
      else if (!w[1]) begin
        pq[k].push_back(w);
        while (pq[k].size() > 0) cq[k].push_back(pq[k].pop_front());
      end else begin
        pq[k].delete();
        drop_exp[k] = 1'b1;
      end
    end else if (stuck) begin
      pq[k].delete();
      dropping[k] = 1'b1;
      drop_exp[k] = 1'b1;
    end
  endtask

  // One clock: compare all outputs, take the edge, advance the model
  task automatic cycle();
    bit    acc [NDUT];
    bit    rd  [NDUT];
    word_t in_w;
    #1;
    in_w = {s_tdata, s_tkeep, s_tuser, s_tlast};
    for (int k = 0; k < NDUT; k++) begin
      acc[k] = exp_ready(k) && s_tvalid;
      rd[k]  = exp_valid(k) && m_tready;
      check($sformatf("d%0d_s_tready", k), 64'(obs_ready[k]), 64'(exp_ready(k)));
      check($sformatf("d%0d_m_tvalid", k), 64'(obs_valid[k]), 64'(exp_valid(k)));
      if (!areset) begin
        check($sformatf("d%0d_fill_count", k), 64'(obs_fill[k]), 64'(words(k)));
        check($sformatf("d%0d_pkt_count", k), 64'(obs_pkt[k]), 64'(pkts(k)));
        check($sformatf("d%0d_drop", k), 64'(obs_drop[k]), 64'(drop_exp[k]));
        if (exp_valid(k)) check($sformatf("d%0d_payload", k), 64'(obs_word[k]), 64'(cq[k][0]));
      end
      if (obs_drop[k]) drop_n[k]++;
      if (obs_valid[k] && m_tready) begin
        rd_n[k]++;
        outq[k].push_back(obs_word[k]);
      end
      acc_flag[k] = acc[k];
    end
    @(posedge aclk);
    for (int k = 0; k < NDUT; k++) update_model(k, acc[k], rd[k], in_w);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic clear_stats();
    for (int k = 0; k < NDUT; k++) begin
      rd_n[k] = 0; drop_n[k] = 0; acc_flag[k] = 1'b0;
      outq[k].delete();
    end
  endtask

  task automatic do_reset(input int n);
    areset   = 1'b1;
    s_tvalid = 1'b0;
    repeat (n) cycle();
    areset = 1'b0;
    clear_stats();
  endtask

  // Present one beat until the chosen lead instance takes it
  task automatic send_beat(input int lead, input logic [DW-1:0] d, input logic u, input logic l);
    int guard = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = KW'($urandom); s_tuser = u; s_tlast = l;
    do begin
      cycle();
      guard++;
    end while (!acc_flag[lead] && guard < 100);
    check($sformatf("d%0d_beat_accepted", lead), 64'(acc_flag[lead]), 64'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int lead, input int len, input int base, input bit bad);
    for (int i = 0; i < len; i++)
      send_beat(lead, DW'(base + i), (i == len - 1) ? bad : 1'b0, i == len - 1);
  endtask

  task automatic check_data(input string tag, input int k, input int first, input int n);
    word_t w;
    check({tag, "_count"}, 64'(outq[k].size()), 64'(n));
    for (int i = 0; i < n && i < outq[k].size(); i++) begin
      w = outq[k][i];
      check($sformatf("%s_data%0d", tag, i), 64'(w[WW-1:KW+2]), 64'(first + i));
    end
  endtask

  initial begin
    int idx;
    int guard;
    int beat;
    int len;
    bit bad;

    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    clear_stats();
    @(posedge aclk);
    #1;
    do_reset(2);
    check("reset_fill", 64'(obs_fill[0]), 64'(0));
    check("reset_valid", 64'(obs_valid[1]), 64'(0));

    // Cut-through: fill to the brim, then drain in order
    m_tready = 1'b0;
    idx = 0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_tdata = DW'(idx); s_tkeep = KW'($urandom); s_tuser = 1'($urandom); s_tlast = 1'b0;
      cycle();
      if (acc_flag[0]) idx++;
    end
    check("ct_accepts_until_full", 64'(idx), 64'(16));
    check("ct_ready_low_when_full", 64'(obs_ready[0]), 64'(0));
    check("ct_fill_at_full", 64'(obs_fill[0]), 64'(16));
    m_tready = 1'b1;
    guard = 0;
    while (idx < 20 && guard < 200) begin
      s_tvalid = 1'b1; s_tdata = DW'(idx); s_tkeep = KW'($urandom); s_tuser = 1'($urandom);
      cycle();
      if (acc_flag[0]) idx++;
      guard++;
    end
    idle(20);
    check_data("ct_order", 0, 0, 20);

    // Cut-through streaming: one write and one read every cycle
    do_reset(1);
    m_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(100 + i); s_tkeep = KW'($urandom);
      s_tuser = 1'b0; s_tlast = (i % 3 == 2);
      cycle();
    end
    check("ct_stream_no_bubbles", 64'(rd_n[0]), 64'(11));
    idle(3);
    check_data("ct_stream", 0, 100, 12);

    // Store-and-forward: one good 3-beat packet
    do_reset(1);
    m_tready = 1'b1;
    send_pkt(1, 3, 200, 1'b0);
    check("pk_valid_after_last", 64'(obs_valid[1]), 64'(1));
    check("pk_count_after_last", 64'(obs_pkt[1]), 64'(1));
    idle(5);
    check("pk_count_drained", 64'(obs_pkt[1]), 64'(0));
    check("pk_fill_drained", 64'(obs_fill[1]), 64'(0));
    check_data("pk_three", 1, 200, 3);

    // Good packet followed by a bad-frame packet
    do_reset(1);
    m_tready = 1'b1;
    send_pkt(1, 2, 300, 1'b0);
    send_pkt(1, 4, 400, 1'b1);
    idle(6);
    check("bad_drop_pulses", 64'(drop_n[1]), 64'(1));
    check("bad_fill_zero", 64'(obs_fill[1]), 64'(0));
    check_data("bad_only_good", 1, 300, 2);

    // Oversize on the small instance, then a packet that exactly fits
    do_reset(1);
    m_tready = 1'b1;
    send_pkt(2, 6, 500, 1'b0);
    check("big_drop_pulses", 64'(drop_n[2]), 64'(1));
    check("big_no_output", 64'(rd_n[2]), 64'(0));
    send_pkt(2, 4, 600, 1'b0);
    idle(6);
    check("big_single_drop", 64'(drop_n[2]), 64'(1));
    check_data("fit_pkt", 2, 600, 4);

    // Reset with a partial packet held
    do_reset(1);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(1, DW'(700 + i), 1'b0, 1'b0);
    check("midrst_fill_before", 64'(obs_fill[1]), 64'(5));
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    #1;
    check("midrst_fill", 64'(obs_fill[1]), 64'(0));
    check("midrst_pkt", 64'(obs_pkt[1]), 64'(0));
    check("midrst_valid", 64'(obs_valid[1]), 64'(0));
    clear_stats();
    m_tready = 1'b1;
    send_pkt(1, 3, 800, 1'b0);
    idle(5);
    check_data("midrst_fresh", 1, 800, 3);

    // Random traffic with back-pressure, bad frames and oversize packets
    do_reset(1);
    beat = 0;
    len  = int'($urandom_range(1, 20));
    bad  = ($urandom % 4) == 0;
    for (int c = 0; c < 3000; c++) begin
      m_tready = ($urandom % 3) != 0;
      s_tvalid = ($urandom % 4) != 0;
      s_tdata  = DW'($urandom);
      s_tkeep  = KW'($urandom);
      s_tlast  = (beat == len - 1);
      s_tuser  = s_tlast ? bad : 1'($urandom);
      cycle();
      if (acc_flag[1]) begin
        beat++;
        if (beat == len) begin
          beat = 0;
          len  = int'($urandom_range(1, 20));
          bad  = ($urandom % 4) == 0;
        end
      end
    end
    m_tready = 1'b1;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Single-clock AXI-Stream FIFO with tkeep/tuser sideband, fill and packet occupancy reporting, and an optional store-and-forward packet mode. In packet mode, bad-frame packets (tuser[0] on tlast) and oversize packets are discarded by write-pointer rollback. It sits between stream producers and consumers in the same clock domain, e.g. ahead of a DMA or framer that needs whole packets before starting.

## Interface
- DATA_WIDTH, 8: tdata width in bits; must be a multiple of 8; tkeep width is DATA_WIDTH/8.
- ADDR_DEPTH, 4: log2 of storage depth; DEPTH = 2**ADDR_DEPTH words.
- USER_WIDTH, 1: tuser width; minimum 1.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward with drop.

- aclk  in  1  single clock; all logic on its rising edge.
- areset  in  1  synchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  write-side data.
- s_tkeep  in  DATA_WIDTH/8  byte qualifiers; stored unmodified.
- s_tuser  in  USER_WIDTH  sideband; bit 0 on the tlast beat is the bad-frame flag in packet mode.
- s_tlast  in  1  end of packet.
- s_tvalid  in  1  write-side valid.
- s_tready  out  1  write-side ready.
- m_tdata, m_tkeep, m_tuser, m_tlast  out  as s_*  read-side payload.
- m_tvalid  out  1  read-side valid.
- m_tready  in  1  read-side ready.
- fill_count  out  ADDR_DEPTH+1  words held, including uncommitted ones.
- pkt_count  out  ADDR_DEPTH+1  complete committed packets held.
- drop  out  1  one-cycle pulse per discarded packet; always 0 when PACKET_MODE=0.

## Operation
- Storage: DEPTH x (DATA_WIDTH + DATA_WIDTH/8 + USER_WIDTH + 1) register array.
  - Write is synchronous.
  - Read is asynchronous at rd_ptr[ADDR_DEPTH-1:0].
- Pointers wr_ptr (speculative), wr_commit and rd_ptr are each ADDR_DEPTH+1 bits.
  - Binary, wrap modulo 2*DEPTH.
  - fill_count = wr_ptr - rd_ptr (modulo arithmetic).
  - full: fill_count == DEPTH.
- Write accept: s_tvalid & s_tready. Read accept: m_tvalid & m_tready.
- PACKET_MODE=0:
  - Every accepted beat is written and wr_commit follows wr_ptr.
  - s_tready = !full & !areset.
  - m_tvalid = (wr_commit != rd_ptr).
  - tuser is pass-through; drop is never asserted.
- PACKET_MODE=1 uses a state machine with two states, ACCEPT and DROP.
- ACCEPT: s_tready = !full.
  - A beat without tlast is written and wr_ptr is incremented.
  - A tlast beat with s_tuser[0]=0 is written and wr_commit <= wr_ptr+1. pkt_count increments unless a tlast beat is read in the same cycle.
  - A tlast beat with s_tuser[0]=1 is not written. wr_ptr <= wr_commit and drop pulses.
  - Oversize: full & (wr_commit == rd_ptr) means the whole FIFO is one unterminated packet. At the next edge: wr_ptr <= wr_commit, state <= DROP, drop pulses.
- DROP: s_tready = 1 and beats are discarded.
  - An accepted tlast beat returns the state to ACCEPT.
  - drop is not pulsed again.
- Read side, PACKET_MODE=1:
  - m_tvalid = (pkt_count != 0).
  - A read of a tlast beat decrements pkt_count.
  - Simultaneous commit and tlast read leave pkt_count unchanged.
- A packet of exactly DEPTH beats is accepted. Its tlast is the DEPTH-th beat, so it is committed before the oversize condition can be evaluated.
- Counters never exceed DEPTH. pkt_count never exceeds the committed word count.

## Timing
- Reset, synchronous: all pointers, fill_count and pkt_count become 0. State becomes ACCEPT and drop becomes 0.
  - s_tready and m_tvalid are 0 during any cycle in which areset is high.
  - Reset mid-packet discards all contents, including partial packets.
- Cut-through latency: a beat accepted at edge N appears on m_* with m_tvalid=1 in cycle N+1.
- Packet-mode latency: m_tvalid rises in the cycle after the edge that accepts tlast.
- Throughput: one write and one read per cycle.
  - When full, a same-cycle read does not raise s_tready; s_tready depends only on registered state.
  - m_tvalid never depends combinationally on s_tvalid.
- m_* payload is stable while m_tvalid=1 and m_tready=0.
- drop is high exactly one cycle: the cycle after the rollback edge.

## Test plan
- PACKET_MODE=0, ADDR_DEPTH=4: write 20 beats back-to-back with m_tready=0.
  - s_tready falls after 16 accepts and fill_count=16.
  - Then set m_tready=1: data 0..15 emerge in order, then 16..19.
- PACKET_MODE=0: write and read simultaneously every cycle.
  - fill_count holds at 1 and there are no bubbles.
  - The first m_tvalid appears the cycle after the first write.
- PACKET_MODE=1: send a 3-beat packet (tkeep 0xF, tlast on beat 3).
  - m_tvalid stays 0 until the cycle after beat 3; pkt_count=1.
  - After the 3 reads pkt_count=0 and fill_count=0.
- PACKET_MODE=1: send packet A (good, 2 beats), then packet B (4 beats, s_tuser[0]=1 on tlast).
  - drop pulses once.
  - Only A's 2 beats are output and fill_count returns to 0.
- PACKET_MODE=1, ADDR_DEPTH=2: send a 6-beat packet with m_tready=1.
  - drop pulses once and the remaining beats are accepted with s_tready=1.
  - No output appears.
  - A following 4-beat packet passes intact.
- Assert areset mid-packet with 5 words stored.
  - The next cycle shows fill_count=0, pkt_count=0 and m_tvalid=0.
  - A fresh packet then passes normally.
